// File: rtl/code_frame_transmitter_if.sv
// rtl/code_frame_transmitter_if.sv - code link handshake and serial line bundle
interface code_frame_transmitter_if;
    logic       start;
    logic [2:0] code;
    logic       match;
    logic       tx;
    logic       busy;
    logic       done;
    logic       fail;
    logic [1:0] retries;

    modport master (
        output start, code, match,
        input  tx, busy, done, fail, retries
    );

    modport slave (
        input  start, code, match,
        output tx, busy, done, fail, retries
    );
endinterface

// File: rtl/code_frame_transmitter.sv
// rtl/code_frame_transmitter.sv - framed, parity-protected serial sender for 3-bit codes with ack timeout and retry
module code_frame_transmitter #(
    parameter int BIT_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    code_frame_transmitter_if.slave bus
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [2:0]    BIT_LAST  = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        DONE,
        FAIL
    } state_t;

    state_t        state, state_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [CW-1:0] cyc_cnt, cyc_next;
    logic [TW-1:0] to_cnt, to_next;
    logic [1:0]    retries_q, retries_next;
    logic [2:0]    code_q, code_next;
    logic          tx_q, tx_next;
    logic          busy_q, busy_next;
    logic [5:0]    frame_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            to_cnt    <= '0;
            retries_q <= '0;
            code_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_next;
            cyc_cnt   <= cyc_next;
            to_cnt    <= to_next;
            retries_q <= retries_next;
            code_q    <= code_next;
            tx_q      <= tx_next;
            busy_q    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_next     = bit_cnt;
        cyc_next     = cyc_cnt;
        to_next      = to_cnt;
        retries_next = retries_q;
        code_next    = code_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    code_next    = bus.code;
                    retries_next = 2'd0;
                    bit_next     = 3'd0;
                    cyc_next     = '0;
                    state_next   = SEND;
                end
            end
            SEND: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_next = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_next   = 3'd0;
                        to_next    = '0;
                        state_next = WAIT_ACK;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    cyc_next = cyc_cnt + CW'(1);
                end
            end
            WAIT_ACK: begin
                // match takes priority over a timeout expiring in the same cycle
                if (bus.match) begin
                    state_next = DONE;
                end else if (to_cnt == TO_LAST) begin
                    to_next = '0;
                    if (retries_q < RETRY_MAX) begin
                        retries_next = retries_q + 2'd1;
                        bit_next     = 3'd0;
                        cyc_next     = '0;
                        state_next   = SEND;
                    end else begin
                        state_next = FAIL;
                    end
                end else begin
                    to_next = to_cnt + TW'(1);
                end
            end
            DONE:    state_next = IDLE;
            FAIL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx and busy are registered from the next-state view so they line up with the state they describe
    always_comb begin
        frame_next = {1'b0, code_next, ^code_next, 1'b1};
        tx_next    = 1'b1;
        if (state_next == SEND) begin
            tx_next = frame_next[BIT_LAST - bit_next];
        end
        busy_next = (state_next != IDLE);
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = (state == DONE);
    assign bus.fail    = (state == FAIL);
    assign bus.retries = retries_q;
endmodule

// File: tb/tb_code_frame_transmitter.sv
// tb/tb_code_frame_transmitter.sv - randomized cycle-accurate check of code_frame_transmitter against a waveform model
module tb_code_frame_transmitter;
    localparam int BC = 4;
    localparam int AT = 16;
    localparam int MR = 3;

    typedef struct {
        logic       start;
        logic [2:0] code;
        logic       match;
        logic [5:0] obs;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_ret;
    step_t plan[$];

    always #5 clk = ~clk;

    code_frame_transmitter_if bus ();

    code_frame_transmitter #(
        .BIT_CYCLES (BC),
        .ACK_TIMEOUT(AT),
        .MAX_RETRY  (MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [5:0] pack(input logic tx, input logic busy, input logic done,
                                        input logic fail, input logic [1:0] r);
        return {tx, busy, done, fail, r};
    endfunction

    function automatic logic [5:0] observed();
        return {bus.tx, bus.busy, bus.done, bus.fail, bus.retries};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got(tx,busy,done,fail,retries)=%b expected=%b", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs after an accepted start: frames of 6 bits held BC cycles,
    // AT idle-high ack cycles per attempt, then a one-cycle done or fail.
    task automatic build(input logic [2:0] c, input int m_att, input int m_w);
        step_t s;
        logic [5:0] fr;
        logic par;
        par = 1'((c[2] + c[1] + c[0]) % 2);
        fr  = {1'b0, c[2], c[1], c[0], par, 1'b1};
        plan.delete();
        for (int a = 0; a <= MR; a++) begin
            for (int n = 0; n < 6; n++) begin
                for (int b = 0; b < BC; b++) begin
                    s.start = 1'($urandom_range(0, 1));
                    s.code  = 3'($urandom_range(0, 7));
                    s.match = 1'($urandom_range(0, 1));
                    s.obs   = pack(fr[5-n], 1'b1, 1'b0, 1'b0, 2'(a));
                    plan.push_back(s);
                end
            end
            for (int w = 0; w < AT; w++) begin
                s.start = 1'($urandom_range(0, 1));
                s.code  = 3'($urandom_range(0, 7));
                s.match = (a == m_att && w == m_w);
                s.obs   = pack(1'b1, 1'b1, 1'b0, 1'b0, 2'(a));
                plan.push_back(s);
                if (a == m_att && w == m_w) begin
                    s.start = 1'b0;
                    s.match = 1'($urandom_range(0, 1));
                    s.obs   = pack(1'b1, 1'b1, 1'b1, 1'b0, 2'(a));
                    plan.push_back(s);
                    exp_ret = 2'(a);
                    return;
                end
            end
        end
        s.start = 1'b0;
        s.match = 1'($urandom_range(0, 1));
        s.obs   = pack(1'b1, 1'b1, 1'b0, 1'b1, 2'(MR));
        plan.push_back(s);
        exp_ret = 2'(MR);
    endtask

    task automatic start_cycle(input logic [2:0] c, input logic [1:0] prev_ret);
        @(negedge clk);
        check("idle_before_start", observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, prev_ret));
        bus.start = 1'b1;
        bus.code  = c;
        bus.match = 1'($urandom_range(0, 1));
    endtask

    task automatic run_txn(input logic [2:0] c, input int m_att, input int m_w);
        logic [1:0] prev_ret;
        prev_ret = exp_ret;
        build(c, m_att, m_w);
        start_cycle(c, prev_ret);
        for (int i = 0; i < plan.size(); i++) begin
            @(negedge clk);
            check($sformatf("code%b_att%0d_w%0d_cyc%0d", c, m_att, m_w, i + 1), observed(), plan[i].obs);
            bus.start = plan[i].start;
            bus.code  = plan[i].code;
            bus.match = plan[i].match;
        end
    endtask

    task automatic reset_mid(input logic [2:0] c, input int abort_j);
        logic [1:0] prev_ret;
        prev_ret = exp_ret;
        build(c, -1, 0);
        start_cycle(c, prev_ret);
        for (int i = 0; i < abort_j; i++) begin
            @(negedge clk);
            check($sformatf("pre_reset_code%b_cyc%0d", c, i + 1), observed(), plan[i].obs);
            bus.start = plan[i].start;
            bus.code  = plan[i].code;
            bus.match = 1'b0;
        end
        rst       = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check($sformatf("after_reset_cyc%0d", abort_j), observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        rst     = 1'b0;
        exp_ret = 2'd0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.code  = 3'd0;
        bus.match = 1'b0;
        exp_ret   = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        rst = 1'b0;

        run_txn(3'b101, 0, 2);
        run_txn(3'b110, -1, 0);
        run_txn(3'b111, 1, 5);
        run_txn(3'b000, MR, AT - 1);
        run_txn(3'b011, 0, 0);
        reset_mid(3'b101, 2 * BC + 2);
        run_txn(3'b101, 0, 3);
        run_txn(3'b010, 2, 7);
        reset_mid(3'b100, 6 * BC + 5);
        run_txn(3'b001, -1, 0);

        for (int t = 0; t < 12; t++) begin
            int ma;
            ma = $urandom_range(0, MR + 1);
            run_txn(3'($urandom_range(0, 7)), (ma == MR + 1) ? -1 : ma, $urandom_range(0, AT - 1));
        end

        @(negedge clk);
        check("final_idle", observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, exp_ret));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
